// File: rtl/bus_datapath_gen.sv
`default_nettype none
// ============================================================================
// Module   : bus_datapath_gen
// Purpose  : Single-bus CPU datapath. Holds a general register file, HI/LO,
//            PC, MAR, MDR, Y and a double-width Z. The ALU has single-cycle
//            ops and iterative signed MUL/DIV. MDR reads use a memory
//            handshake, and a sticky flag records any bus contention.
// Revision : 1.0 - initial release
// ============================================================================
module bus_datapath_gen #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter bit R0_ZERO  = 1'b0,
  parameter int PC_STEP  = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_REGS-1:0] reg_in,
  input  logic [NUM_REGS-1:0] reg_out,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                pc_in,
  input  logic                mar_in,
  input  logic                y_in,
  input  logic                mdr_in,
  input  logic                hi_out,
  input  logic                lo_out,
  input  logic                pc_out,
  input  logic                mdr_out,
  input  logic                zhi_out,
  input  logic                zlo_out,
  input  logic                inc_pc,
  input  logic [4:0]          alu_op,
  input  logic                alu_start,
  input  logic                mem_read,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [DATA_W-1:0]   mar_q,
  output logic [DATA_W-1:0]   bus_q,
  output logic                alu_busy,
  output logic                alu_done,
  output logic                mem_stall,
  output logic                bus_conflict
);

  localparam int                C_SH_W    = $clog2(DATA_W);
  localparam int                C_NDRV    = NUM_REGS + 6;
  localparam logic [C_SH_W-1:0] C_LAST    = C_SH_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] C_PC_STEP = DATA_W'(PC_STEP);

  localparam logic [4:0] C_OP_ADD  = 5'd0;
  localparam logic [4:0] C_OP_SUB  = 5'd1;
  localparam logic [4:0] C_OP_AND  = 5'd2;
  localparam logic [4:0] C_OP_OR   = 5'd3;
  localparam logic [4:0] C_OP_SHR  = 5'd4;
  localparam logic [4:0] C_OP_SHRA = 5'd5;
  localparam logic [4:0] C_OP_SHL  = 5'd6;
  localparam logic [4:0] C_OP_ROR  = 5'd7;
  localparam logic [4:0] C_OP_ROL  = 5'd8;
  localparam logic [4:0] C_OP_NEG  = 5'd9;
  localparam logic [4:0] C_OP_NOT  = 5'd10;
  localparam logic [4:0] C_OP_MUL  = 5'd11;
  localparam logic [4:0] C_OP_DIV  = 5'd12;

  typedef enum logic [0:0] {MDR_IDLE = 1'b0, MDR_WAIT = 1'b1} mdr_state_t;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_hi, r_lo, r_pc, r_mar, r_mdr, r_y;
  logic [2*DATA_W-1:0] r_z;
  logic                r_conflict;
  mdr_state_t          r_mdr_state, w_mdr_nxt;
  logic                w_stall, w_mdr_ld_bus, w_mdr_ld_mem;
  logic [DATA_W-1:0]   w_bus;
  logic [C_NDRV-1:0]   w_drv;
  logic                w_multi;

  // Bus source select: later assignments win, so the highest-priority
  // source (lowest register index) is applied last.
  always_comb begin
    w_bus = '0;
    if (mdr_out) w_bus = r_mdr;
    if (pc_out)  w_bus = r_pc;
    if (zlo_out) w_bus = r_z[DATA_W-1:0];
    if (zhi_out) w_bus = r_z[2*DATA_W-1:DATA_W];
    if (lo_out)  w_bus = r_lo;
    if (hi_out)  w_bus = r_hi;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (reg_out[i]) w_bus = (R0_ZERO && i == 0) ? '0 : r_regs[i];
    end
  end

  // More than one drive enable: clear the lowest set bit and test the rest.
  assign w_drv   = {reg_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out};
  assign w_multi = |(w_drv & (w_drv - C_NDRV'(1)));

  // General register file loads from the bus; R0 may be hard-wired to zero.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_in[i] && !(R0_ZERO && i == 0)) r_regs[i] <= w_bus;
      end
    end
  end

  // Special registers loaded from the bus, PC update and sticky contention flag.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_pc       <= '0;
      r_mar      <= '0;
      r_y        <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (hi_in)  r_hi  <= w_bus;
      if (lo_in)  r_lo  <= w_bus;
      if (mar_in) r_mar <= w_bus;
      if (y_in)   r_y   <= w_bus;
      if (pc_in)       r_pc <= w_bus;
      else if (inc_pc) r_pc <= r_pc + C_PC_STEP;
      if (w_multi) r_conflict <= 1'b1;
    end
  end

  // MDR handshake state register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_mdr_state <= MDR_IDLE;
    else       r_mdr_state <= w_mdr_nxt;
  end

  // MDR next state, stall output and load-source selects.
  always_comb begin
    w_mdr_nxt    = r_mdr_state;
    w_stall      = 1'b0;
    w_mdr_ld_bus = 1'b0;
    w_mdr_ld_mem = 1'b0;
    case (r_mdr_state)
      MDR_IDLE: begin
        if (mdr_in) begin
          if (!mem_read) begin
            w_mdr_ld_bus = 1'b1;
          end else if (mem_ready) begin
            w_mdr_ld_mem = 1'b1;
          end else begin
            w_mdr_nxt = MDR_WAIT;
            w_stall   = 1'b1;
          end
        end
      end
      MDR_WAIT: begin
        w_stall = 1'b1;
        if (mem_ready) begin
          w_mdr_ld_mem = 1'b1;
          w_mdr_nxt    = MDR_IDLE;
        end
      end
      default: w_mdr_nxt = MDR_IDLE;
    endcase
  end

  // MDR data register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)             r_mdr <= '0;
    else if (w_mdr_ld_mem) r_mdr <= mem_data;
    else if (w_mdr_ld_bus) r_mdr <= w_bus;
  end

  // ---------------------------------------------------------------- ALU
  logic [DATA_W-1:0]   w_a, w_b, w_res, w_a_mag, w_b_mag;
  logic [C_SH_W-1:0]   w_sh;
  logic [2*DATA_W-1:0] w_dbl, w_rot_r, w_rot_l;
  logic                w_op_iter;

  assign w_a       = r_y;
  assign w_b       = w_bus;
  assign w_sh      = w_b[C_SH_W-1:0];
  assign w_dbl     = {w_a, w_a};
  assign w_rot_r   = w_dbl >> w_sh;
  assign w_rot_l   = w_dbl << w_sh;
  assign w_a_mag   = w_a[DATA_W-1] ? -w_a : w_a;
  assign w_b_mag   = w_b[DATA_W-1] ? -w_b : w_b;
  assign w_op_iter = (alu_op == C_OP_MUL) || (alu_op == C_OP_DIV);

  // Single-cycle result; unused opcodes produce zero.
  always_comb begin
    w_res = '0;
    case (alu_op)
      C_OP_ADD:  w_res = w_a + w_b;
      C_OP_SUB:  w_res = w_a - w_b;
      C_OP_AND:  w_res = w_a & w_b;
      C_OP_OR:   w_res = w_a | w_b;
      C_OP_SHR:  w_res = w_a >> w_sh;
      C_OP_SHRA: w_res = $signed(w_a) >>> w_sh;
      C_OP_SHL:  w_res = w_a << w_sh;
      C_OP_ROR:  w_res = w_rot_r[DATA_W-1:0];
      C_OP_ROL:  w_res = w_rot_l[2*DATA_W-1:DATA_W];
      C_OP_NEG:  w_res = -w_b;
      C_OP_NOT:  w_res = ~w_b;
      default:   w_res = '0;
    endcase
  end

  // Iterative engine: unsigned magnitudes with a sign fix-up on the last step.
  // MUL is shift-add (acc:q shifts right); DIV is restoring (acc:q shifts left).
  logic                r_busy, r_done, r_is_div, r_neg_q, r_neg_r, r_b_zero;
  logic [C_SH_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_acc, r_q, r_mb, r_a_raw;
  logic [DATA_W:0]     w_sum, w_rsh, w_trial;
  logic [DATA_W-1:0]   w_acc_nxt, w_q_nxt;
  logic [2*DATA_W-1:0] w_prod, w_mul_z, w_div_z;

  // One iteration step of the active multi-cycle operation.
  always_comb begin
    w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mb} : '0);
    w_rsh   = {r_acc, r_q[DATA_W-1]};
    w_trial = w_rsh - {1'b0, r_mb};
    if (r_is_div) begin
      if (!w_trial[DATA_W]) begin
        w_acc_nxt = w_trial[DATA_W-1:0];
        w_q_nxt   = {r_q[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_rsh[DATA_W-1:0];
        w_q_nxt   = {r_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_sum[DATA_W:1];
      w_q_nxt   = {w_sum[0], r_q[DATA_W-1:1]};
    end
  end

  assign w_prod  = {w_acc_nxt, w_q_nxt};
  assign w_mul_z = r_neg_q ? -w_prod : w_prod;
  assign w_div_z = r_b_zero ? {r_a_raw, {DATA_W{1'b1}}}
                            : {(r_neg_r ? -w_acc_nxt : w_acc_nxt),
                               (r_neg_q ? -w_q_nxt   : w_q_nxt)};

  // ALU sequencing: launch, iterate, write Z and pulse done.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_z      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_mb     <= '0;
      r_a_raw  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
        if (r_cnt == C_LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_z    <= r_is_div ? w_div_z : w_mul_z;
        end else begin
          r_cnt <= r_cnt + C_SH_W'(1);
        end
      end else if (alu_start) begin
        if (w_op_iter) begin
          r_busy   <= 1'b1;
          r_cnt    <= '0;
          r_acc    <= '0;
          r_is_div <= (alu_op == C_OP_DIV);
          r_neg_q  <= w_a[DATA_W-1] ^ w_b[DATA_W-1];
          r_neg_r  <= w_a[DATA_W-1];
          r_b_zero <= (w_b == '0);
          r_a_raw  <= w_a;
          r_q      <= (alu_op == C_OP_DIV) ? w_a_mag : w_b_mag;
          r_mb     <= (alu_op == C_OP_DIV) ? w_b_mag : w_a_mag;
        end else begin
          r_z    <= {{DATA_W{1'b0}}, w_res};
          r_done <= 1'b1;
        end
      end
    end
  end

  assign mar_q        = r_mar;
  assign bus_q        = w_bus;
  assign alu_busy     = r_busy;
  assign alu_done     = r_done;
  assign mem_stall    = w_stall;
  assign bus_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_bus_datapath_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_datapath_gen
// Purpose  : Self-checking bench for bus_datapath_gen (32-bit, 16 regs, R0=0)
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_datapath_gen;

  logic        clock, clear;
  logic [15:0] reg_in, reg_out;
  logic        hi_in, lo_in, pc_in, mar_in, y_in, mdr_in;
  logic        hi_out, lo_out, pc_out, mdr_out, zhi_out, zlo_out;
  logic        inc_pc, alu_start, mem_read, mem_ready;
  logic [4:0]  alu_op;
  logic [31:0] mem_data, mar_q, bus_q;
  logic        alu_busy, alu_done, mem_stall, bus_conflict;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_regs [16];

  bus_datapath_gen #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1'b1), .PC_STEP(1)) dut (
    .clock(clock), .clear(clear), .reg_in(reg_in), .reg_out(reg_out),
    .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .mar_in(mar_in), .y_in(y_in),
    .mdr_in(mdr_in), .hi_out(hi_out), .lo_out(lo_out), .pc_out(pc_out),
    .mdr_out(mdr_out), .zhi_out(zhi_out), .zlo_out(zlo_out), .inc_pc(inc_pc),
    .alu_op(alu_op), .alu_start(alu_start), .mem_read(mem_read),
    .mem_ready(mem_ready), .mem_data(mem_data), .mar_q(mar_q), .bus_q(bus_q),
    .alu_busy(alu_busy), .alu_done(alu_done), .mem_stall(mem_stall),
    .bus_conflict(bus_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference ALU computed directly from the operation definitions.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          s;
    longint      sa, sb, q, r;
    logic [31:0] t;
    logic [63:0] w, wq, wr;
    s  = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = a;
    case (op)
      5'd0:  return {32'd0, a + b};
      5'd1:  return {32'd0, a - b};
      5'd2:  return {32'd0, a & b};
      5'd3:  return {32'd0, a | b};
      5'd4:  return {32'd0, a >> s};
      5'd5:  begin w = sa >>> s; return {32'd0, w[31:0]}; end
      5'd6:  return {32'd0, a << s};
      5'd7:  begin repeat (s) t = {t[0], t[31:1]}; return {32'd0, t}; end
      5'd8:  begin repeat (s) t = {t[30:0], t[31]}; return {32'd0, t}; end
      5'd9:  return {32'd0, 32'd0 - b};
      5'd10: return {32'd0, ~b};
      5'd11: return sa * sb;
      5'd12: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb; wq = q; wr = r;
        return {wr[31:0], wq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    reg_in = '0; reg_out = '0; hi_in = 0; lo_in = 0; pc_in = 0; mar_in = 0; y_in = 0;
    mdr_in = 0; hi_out = 0; lo_out = 0; pc_out = 0; mdr_out = 0; zhi_out = 0;
    zlo_out = 0; inc_pc = 0; alu_start = 0; mem_read = 0; mem_ready = 0;
    alu_op = '0; mem_data = '0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    mdr_in = 1; mem_read = 1; mem_ready = 1; mem_data = v;
    tick();
    mdr_in = 0; mem_read = 0; mem_ready = 0;
  endtask

  task automatic put_reg(input int idx, input logic [31:0] v);
    load_mdr(v);
    mdr_out = 1; reg_in = 16'(1) << idx;
    tick();
    mdr_out = 0; reg_in = '0;
    if (idx != 0) m_regs[idx] = v;
  endtask

  task automatic put_y(input logic [31:0] v);
    load_mdr(v);
    mdr_out = 1; y_in = 1;
    tick();
    mdr_out = 0; y_in = 0;
  endtask

  task automatic start_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    put_y(a);
    load_mdr(b);
    mdr_out = 1; alu_op = op; alu_start = 1;
    tick();
    mdr_out = 0; alu_start = 0;
  endtask

  task automatic read_z(output logic [63:0] z);
    zlo_out = 1; #1 z[31:0] = bus_q;
    zlo_out = 0; zhi_out = 1; #1 z[63:32] = bus_q;
    zhi_out = 0;
  endtask

  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (alu_busy === 1'b1 && cycles < 64) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [63:0] z;
    clear = 1; idle_inputs();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    repeat (2) tick();
    clear = 0;
    checks++; if ({alu_busy, alu_done, mem_stall, bus_conflict} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000",
                         {alu_busy, alu_done, mem_stall, bus_conflict}); end
    checks++; if (bus_q !== 32'd0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", bus_q); end
    put_reg(3, 32'h1234_5678);
    reg_out = 16'h0008; #1;
    checks++; if (bus_q !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_r3_load: got %h expected 12345678", bus_q); end
    reg_out = '0;
    load_mdr(32'hA5A5_0001);
    mdr_out = 1; mar_in = 1; pc_in = 1; hi_in = 1; lo_in = 1; tick();
    idle_inputs();
    start_alu(5'd11, 32'd1234, 32'd5678);
    repeat (5) tick();
    checks++; if (alu_busy !== 1'b1) begin
      errors++; $display("FAIL reset_mul_running: busy got %b expected 1", alu_busy); end
    #2 clear = 1; #1;
    checks++; if (alu_busy !== 1'b0 || mar_q !== 32'd0) begin
      errors++; $display("FAIL reset_async: busy=%b mar=%h expected 0/0", alu_busy, mar_q); end
    tick();
    clear = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    for (int i = 0; i < 16; i++) begin
      reg_out = 16'(1) << i; #1;
      checks++; if (bus_q !== 32'd0) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected 0", i, bus_q); end
      reg_out = '0; tick();
    end
    hi_out = 1; #1;
    checks++; if (bus_q !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus_q); end
    hi_out = 0; pc_out = 1; #1;
    checks++; if (bus_q !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus_q); end
    pc_out = 0; mdr_out = 1; #1;
    checks++; if (bus_q !== 32'd0) begin errors++; $display("FAIL reset_mdr: got %h expected 0", bus_q); end
    mdr_out = 0;
    read_z(z);
    checks++; if (z !== 64'd0 || alu_busy !== 1'b0) begin
      errors++; $display("FAIL reset_z: got %h busy %b expected 0", z, alu_busy); end
    tick();
  endtask

  task automatic test_add();
    logic [63:0] z;
    put_reg(1, 32'd1);
    put_y(32'h7FFF_FFFF);
    reg_out = 16'h0002; alu_op = 5'd0; alu_start = 1;
    tick();
    reg_out = '0; alu_start = 0;
    checks++; if (alu_done !== 1'b1) begin
      errors++; $display("FAIL add_done: got %b expected 1", alu_done); end
    read_z(z);
    checks++; if (z !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL add_z: got %h expected 0000000080000000", z); end
    tick();
    checks++; if (alu_done !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse: got %b expected 0", alu_done); end
  endtask

  task automatic test_single_random();
    logic [63:0] z, exp;
    logic [31:0] a, b;
    logic [4:0]  op;
    int          r;
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 29);
      op = (r <= 10) ? 5'(r) : 5'(r + 2);
      a  = $urandom; b = $urandom;
      if (n < 4) a = 32'h8000_0000 >> n;
      exp = ref_alu(op, a, b);
      start_alu(op, a, b);
      checks++; if (alu_done !== 1'b1) begin
        errors++; $display("FAIL single_done op=%0d: got %b expected 1", op, alu_done); end
      read_z(z);
      checks++; if (z !== exp) begin
        errors++; $display("FAIL single op=%0d a=%h b=%h: got %h expected %h", op, a, b, z, exp); end
    end
  endtask

  task automatic test_mul();
    logic [63:0] z, exp;
    logic [31:0] a, b;
    int          cyc;
    start_alu(5'd11, 32'hFFFF_FFFD, 32'd7);
    checks++; if (alu_busy !== 1'b1 || alu_done !== 1'b0) begin
      errors++; $display("FAIL mul_busy_start: busy=%b done=%b expected 1/0", alu_busy, alu_done); end
    // Disturb Y, the bus and try a second start while iterating.
    mdr_out = 1; y_in = 1; alu_op = 5'd0; alu_start = 1;
    tick();
    mdr_out = 0; y_in = 0; alu_start = 0;
    wait_busy(cyc);
    cyc = cyc + 1;
    checks++; if (cyc !== 32) begin
      errors++; $display("FAIL mul_busy_cycles: got %0d expected 32", cyc); end
    checks++; if (alu_done !== 1'b1) begin
      errors++; $display("FAIL mul_done: got %b expected 1", alu_done); end
    read_z(z);
    checks++; if (z !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mul_z: got %h expected FFFFFFFFFFFFFFEB", z); end
    tick();
    checks++; if (alu_done !== 1'b0 || alu_busy !== 1'b0) begin
      errors++; $display("FAIL mul_after: done=%b busy=%b expected 0/0", alu_done, alu_busy); end
    for (int n = 0; n < 6; n++) begin
      a = $urandom; b = $urandom;
      if (n == 0) a = 32'h8000_0000;
      if (n == 1) b = 32'h8000_0000;
      exp = ref_alu(5'd11, a, b);
      start_alu(5'd11, a, b);
      wait_busy(cyc);
      read_z(z);
      checks++; if (cyc !== 32 || z !== exp) begin
        errors++; $display("FAIL mul_rand a=%h b=%h: got %h cyc %0d expected %h cyc 32", a, b, z, cyc, exp); end
    end
  endtask

  task automatic test_div();
    logic [63:0] z, exp;
    logic [31:0] a [10];
    logic [31:0] b [10];
    int          cyc;
    a[0] = 32'd17; b[0] = 32'hFFFF_FFFB;
    a[1] = 32'd9;  b[1] = 32'd0;
    a[2] = 32'hFFFF_FFEF; b[2] = 32'd5;
    a[3] = 32'h8000_0000; b[3] = 32'hFFFF_FFFF;
    a[4] = 32'hFFFF_FFF0; b[4] = 32'd0;
    for (int n = 5; n < 10; n++) begin
      a[n] = $urandom;
      b[n] = (n % 2 == 1) ? $urandom : $urandom_range(1, 300);
    end
    for (int n = 0; n < 10; n++) begin
      exp = ref_alu(5'd12, a[n], b[n]);
      start_alu(5'd12, a[n], b[n]);
      wait_busy(cyc);
      checks++; if (cyc !== 32 || alu_done !== 1'b1) begin
        errors++; $display("FAIL div_timing a=%h b=%h: cyc %0d done %b expected 32/1", a[n], b[n], cyc, alu_done); end
      read_z(z);
      checks++; if (z !== exp) begin
        errors++; $display("FAIL div a=%h b=%h: got %h expected %h", a[n], b[n], z, exp); end
    end
  endtask

  task automatic test_memory();
    logic [31:0] v;
    mdr_in = 1; mem_read = 1; mem_ready = 0; mem_data = 32'h1111_2222; #1;
    checks++; if (mem_stall !== 1'b1) begin
      errors++; $display("FAIL mem_stall_c1: got %b expected 1", mem_stall); end
    tick();
    mdr_in = 0; mem_read = 0; mem_data = $urandom;
    checks++; if (mem_stall !== 1'b1) begin
      errors++; $display("FAIL mem_stall_c2: got %b expected 1", mem_stall); end
    tick();
    checks++; if (mem_stall !== 1'b1) begin
      errors++; $display("FAIL mem_stall_c3: got %b expected 1", mem_stall); end
    mem_ready = 1; mem_data = 32'hCAFE_F00D;
    tick();
    mem_ready = 0; mem_data = 32'd0;
    checks++; if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL mem_stall_end: got %b expected 0", mem_stall); end
    mdr_out = 1; #1;
    checks++; if (bus_q !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL mem_mdr_wait: got %h expected CAFEF00D", bus_q); end
    mdr_out = 0;
    tick();
    v = $urandom;
    mdr_in = 1; mem_read = 1; mem_ready = 1; mem_data = v; #1;
    checks++; if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL mem_nostall: got %b expected 0", mem_stall); end
    tick();
    idle_inputs();
    mdr_out = 1; #1;
    checks++; if (bus_q !== v) begin
      errors++; $display("FAIL mem_mdr_fast: got %h expected %h", bus_q, v); end
    mdr_out = 0;
    tick();
  endtask

  task automatic test_regs();
    int          idx, k;
    logic [31:0] v;
    for (int n = 0; n < 12; n++) begin
      idx = $urandom_range(1, 15);
      put_reg(idx, $urandom);
    end
    for (int i = 1; i < 16; i++) begin
      reg_out = 16'(1) << i; #1;
      checks++; if (bus_q !== m_regs[i]) begin
        errors++; $display("FAIL reg_read%0d: got %h expected %h", i, bus_q, m_regs[i]); end
      reg_out = '0; tick();
    end
    // MDR from the bus, then HI, LO and MAR from MDR.
    k = $urandom_range(1, 15);
    reg_out = 16'(1) << k; mdr_in = 1; tick();
    reg_out = '0; mdr_in = 0;
    mdr_out = 1; hi_in = 1; lo_in = 1; mar_in = 1; tick();
    idle_inputs();
    checks++; if (mar_q !== m_regs[k]) begin
      errors++; $display("FAIL mar_load: got %h expected %h", mar_q, m_regs[k]); end
    lo_out = 1; #1;
    checks++; if (bus_q !== m_regs[k]) begin
      errors++; $display("FAIL lo_load: got %h expected %h", bus_q, m_regs[k]); end
    lo_out = 0;
    v = $urandom;
    load_mdr(v);
    mdr_out = 1; hi_in = 1; tick(); idle_inputs();
    hi_out = 1; #1;
    checks++; if (bus_q !== v) begin
      errors++; $display("FAIL hi_load: got %h expected %h", bus_q, v); end
    hi_out = 0;
    tick();
  endtask

  task automatic test_conflict_r0_pc();
    logic [31:0] v;
    put_reg(0, 32'hDEAD_BEEF);
    reg_out = 16'h0001; #1;
    checks++; if (bus_q !== 32'd0) begin
      errors++; $display("FAIL r0_zero: got %h expected 0", bus_q); end
    reg_out = '0;
    checks++; if (bus_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_clean: got %b expected 0", bus_conflict); end
    load_mdr(32'h0000_0055);
    mdr_out = 1; pc_in = 1; inc_pc = 1; tick(); idle_inputs();
    pc_out = 1; #1;
    checks++; if (bus_q !== 32'h55) begin
      errors++; $display("FAIL pc_in_priority: got %h expected 00000055", bus_q); end
    pc_out = 0; inc_pc = 1; tick(); inc_pc = 0;
    pc_out = 1; #1;
    checks++; if (bus_q !== 32'h56) begin
      errors++; $display("FAIL pc_inc: got %h expected 00000056", bus_q); end
    pc_out = 0;
    load_mdr(32'hFFFF_FFFF);
    mdr_out = 1; pc_in = 1; tick(); idle_inputs();
    inc_pc = 1; tick(); inc_pc = 0;
    pc_out = 1; #1;
    checks++; if (bus_q !== 32'd0) begin
      errors++; $display("FAIL pc_wrap: got %h expected 0", bus_q); end
    pc_out = 0;
    v = $urandom;
    put_reg(2, v);
    checks++; if (bus_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_still_clean: got %b expected 0", bus_conflict); end
    reg_out = 16'h0004; pc_out = 1; #1;
    checks++; if (bus_q !== v) begin
      errors++; $display("FAIL conflict_priority: got %h expected %h", bus_q, v); end
    tick();
    reg_out = '0; pc_out = 0;
    checks++; if (bus_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_set: got %b expected 1", bus_conflict); end
    repeat (3) tick();
    checks++; if (bus_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_sticky: got %b expected 1", bus_conflict); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_random();
    test_mul();
    test_div();
    test_memory();
    test_regs();
    test_conflict_r0_pc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
